// File: rtl/chrom_loader.sv
// chrom_loader: serial chromosome writer that fills per-element gene shadows and commits them atomically
module chrom_loader #(
  parameter int N_LE   = 8,
  parameter int FUNC_W = 3,
  parameter int SEL_W  = 6,
  parameter int NUM_IN = 36
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      ser_valid_i,
  input  logic                      ser_data_i,
  output logic                      ser_ready_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [N_LE*FUNC_W-1:0]    conf_func_o,
  output logic [N_LE*2*SEL_W-1:0]   conf_ins_o
);
  localparam int GENE_W = FUNC_W + 2 * SEL_W;
  localparam int BW     = $clog2(GENE_W);
  localparam int GW     = $clog2(N_LE + 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t                    state_q, state_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]             gene_cnt_q, gene_cnt_d;
  logic [GENE_W-2:0]         shift_q, shift_d;
  logic                      bad_q, bad_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;
  logic [N_LE*FUNC_W-1:0]    shadow_func_q, shadow_func_d;
  logic [N_LE*2*SEL_W-1:0]   shadow_ins_q, shadow_ins_d;
  logic [N_LE*FUNC_W-1:0]    conf_func_q, conf_func_d;
  logic [N_LE*2*SEL_W-1:0]   conf_ins_q, conf_ins_d;
  logic                      xfer, gene_end, gene_bad, last;
  logic [GENE_W-1:0]         gene_w;
  assign ser_ready_o = state_q == LOAD;
  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign conf_func_o = conf_func_q;
  assign conf_ins_o  = conf_ins_q;
  assign xfer     = ser_valid_i && ser_ready_o;
  assign gene_w   = {shift_q, ser_data_i};
  assign gene_end = xfer && bit_cnt_q == BW'(GENE_W - 1);
  // the completing gene is checked in the same cycle it lands in the shadow
  assign gene_bad = int'(gene_w[SEL_W-1:0]) >= NUM_IN || int'(gene_w[2*SEL_W-1:SEL_W]) >= NUM_IN;
  assign last     = gene_end && gene_cnt_q == GW'(N_LE - 1);
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    gene_cnt_d    = gene_cnt_q;
    shift_d       = shift_q;
    bad_d         = bad_q;
    err_d         = err_q;
    done_d        = 1'b0;
    shadow_func_d = shadow_func_q;
    shadow_ins_d  = shadow_ins_q;
    conf_func_d   = conf_func_q;
    conf_ins_d    = conf_ins_q;
    case (state_q)
      IDLE: if (start_i && !abort_i) begin
        state_d    = LOAD;
        bit_cnt_d  = '0;
        gene_cnt_d = '0;
        bad_d      = 1'b0;
        err_d      = 1'b0;
      end
      LOAD: if (abort_i) begin
        state_d = IDLE;
      end else if (xfer) begin
        shift_d   = gene_w[GENE_W-2:0];
        bit_cnt_d = gene_end ? '0 : bit_cnt_q + 1'b1;
        if (gene_end) begin
          shadow_func_d[gene_cnt_q*FUNC_W +: FUNC_W]   = gene_w[GENE_W-1 -: FUNC_W];
          shadow_ins_d[gene_cnt_q*2*SEL_W +: 2*SEL_W]  = gene_w[2*SEL_W-1:0];
          gene_cnt_d = gene_cnt_q + 1'b1;
          bad_d      = bad_q || gene_bad;
        end
        if (last) begin
          state_d = (bad_q || gene_bad) ? IDLE : COMMIT;
          err_d   = bad_q || gene_bad;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (!abort_i) begin
          conf_func_d = shadow_func_q;
          conf_ins_d  = shadow_ins_q;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      gene_cnt_q    <= '0;
      shift_q       <= '0;
      bad_q         <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      shadow_func_q <= '0;
      shadow_ins_q  <= '0;
      conf_func_q   <= '0;
      conf_ins_q    <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      gene_cnt_q    <= gene_cnt_d;
      shift_q       <= shift_d;
      bad_q         <= bad_d;
      err_q         <= err_d;
      done_q        <= done_d;
      shadow_func_q <= shadow_func_d;
      shadow_ins_q  <= shadow_ins_d;
      conf_func_q   <= conf_func_d;
      conf_ins_q    <= conf_ins_d;
    end
  end
endmodule

// File: tb/tb_chrom_loader.sv
// tb_chrom_loader: directed self-checking bench for chrom_loader with a two-element chromosome
module tb_chrom_loader;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, sv = 1'b0, sd = 1'b0;
  logic ready, busy, done, err;
  logic [5:0]  cfunc;
  logic [23:0] cins;
  int total = 0, bad = 0;
  localparam logic [29:0] F1 = {15'b011_000111_000101, 15'b110_100011_000000};
  localparam logic [29:0] F2 = {15'b011_000111_000101, 15'b110_100011_100100};
  localparam logic [29:0] F3 = {15'b001_000010_000001, 15'b101_000100_000011};
  localparam logic [29:0] F4 = {15'b011_111111_000101, 15'b110_100011_000000};
  localparam logic [5:0]  E1_FUNC = 6'b110_011;
  localparam logic [23:0] E1_INS  = 24'h8C01C5;
  localparam logic [5:0]  E3_FUNC = 6'b101_001;
  localparam logic [23:0] E3_INS  = 24'h103081;
  always #5 clk = ~clk;
  chrom_loader #(.N_LE(2)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .ser_valid_i(sv), .ser_data_i(sd), .ser_ready_o(ready), .busy_o(busy),
    .done_o(done), .err_o(err), .conf_func_o(cfunc), .conf_ins_o(cins)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_bits(input logic [29:0] f, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      sv = 1'b1;
      sd = f[29-k];
      tick();
    end
    sv = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (cfunc !== 6'd0) begin bad++; $display("FAIL reset_func got=%h want=0", cfunc); end
    total++; if (cins !== 24'd0) begin bad++; $display("FAIL reset_ins got=%h want=0", cins); end
    total++; if ({ready, busy, done, err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {ready, busy, done, err}); end
    sv = 1'b1;
    sd = 1'b1;
    tick();
    tick();
    sv = 1'b0;
    total++; if (dut.bit_cnt_q !== 4'd0 || ready !== 1'b0) begin bad++; $display("FAIL idle_ignores_ser got=%0d/%b want=0/0", dut.bit_cnt_q, ready); end
  endtask
  task automatic test_basic();
    begin_frame();
    total++; if ({ready, busy} !== 2'b11) begin bad++; $display("FAIL load_entry got=%b want=11", {ready, busy}); end
    send_bits(F1, 0, 30);
    total++; if ({done, busy} !== 2'b01) begin bad++; $display("FAIL basic_t1 got=%b want=01", {done, busy}); end
    tick();
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL basic_t2 got=%b want=10", {done, busy}); end
    total++; if (cfunc !== E1_FUNC) begin bad++; $display("FAIL basic_func got=%b want=%b", cfunc, E1_FUNC); end
    total++; if (cins !== E1_INS) begin bad++; $display("FAIL basic_ins got=%h want=%h", cins, E1_INS); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
  endtask
  task automatic test_stall();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin_frame();
    for (int k = 0; k < 30; k++) begin
      sv = 1'b1;
      sd = F1[29-k];
      tick();
      sv = 1'b0;
      if (k < 29) begin
        n = $urandom_range(1, 3);
        repeat (n) begin
          sd = 1'($urandom);
          tick();
          total++; if (dut.bit_cnt_q !== 4'((k + 1) % 15)) begin bad++; $display("FAIL stall_hold bit=%0d got=%0d want=%0d", k, dut.bit_cnt_q, (k + 1) % 15); end
        end
      end
    end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", done); end
    total++; if ({cfunc, cins} !== {E1_FUNC, E1_INS}) begin bad++; $display("FAIL stall_conf got=%h/%h want=%h/%h", cfunc, cins, E1_FUNC, E1_INS); end
  endtask
  task automatic test_bad_select();
    begin_frame();
    send_bits(F2, 0, 30);
    total++; if ({err, busy} !== 2'b10) begin bad++; $display("FAIL bad_err got=%b want=10", {err, busy}); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL bad_no_done got=%b want=0", done); end
    total++; if ({cfunc, cins} !== {E1_FUNC, E1_INS}) begin bad++; $display("FAIL bad_keep got=%h/%h want=%h/%h", cfunc, cins, E1_FUNC, E1_INS); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    begin_frame();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
    send_bits(F3, 0, 30);
    tick();
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL recover_flags got=%b want=10", {done, err}); end
    total++; if ({cfunc, cins} !== {E3_FUNC, E3_INS}) begin bad++; $display("FAIL recover_conf got=%h/%h want=%h/%h", cfunc, cins, E3_FUNC, E3_INS); end
    begin_frame();
    send_bits(F4, 0, 30);
    tick();
    total++; if ({done, err} !== 2'b01) begin bad++; $display("FAIL bad_gene0 got=%b want=01", {done, err}); end
    total++; if ({cfunc, cins} !== {E3_FUNC, E3_INS}) begin bad++; $display("FAIL bad_gene0_keep got=%h/%h want=%h/%h", cfunc, cins, E3_FUNC, E3_INS); end
  endtask
  task automatic test_abort();
    begin_frame();
    send_bits(F1, 0, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if ({ready, busy, err} !== 3'b000) begin bad++; $display("FAIL abort_idle got=%b want=000", {ready, busy, err}); end
    tick();
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", done); end
    total++; if ({cfunc, cins} !== {E3_FUNC, E3_INS}) begin bad++; $display("FAIL abort_keep got=%h/%h want=%h/%h", cfunc, cins, E3_FUNC, E3_INS); end
    begin_frame();
    send_bits(F1, 0, 30);
    tick();
    total++; if ({done, cfunc, cins} !== {1'b1, E1_FUNC, E1_INS}) begin bad++; $display("FAIL abort_reload got=%b/%h/%h want=1/%h/%h", done, cfunc, cins, E1_FUNC, E1_INS); end
    begin_frame();
    send_bits(F3, 0, 29);
    sv = 1'b1;
    sd = F3[0];
    abort = 1'b1;
    tick();
    sv = 1'b0;
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_last_idle got=%b want=0", busy); end
    tick();
    total++; if ({done, cfunc, cins} !== {1'b0, E1_FUNC, E1_INS}) begin bad++; $display("FAIL abort_last got=%b/%h/%h want=0/%h/%h", done, cfunc, cins, E1_FUNC, E1_INS); end
    begin_frame();
    send_bits(F3, 0, 30);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if ({done, busy, cfunc, cins} !== {2'b00, E1_FUNC, E1_INS}) begin bad++; $display("FAIL abort_commit got=%b%b/%h/%h want=00/%h/%h", done, busy, cfunc, cins, E1_FUNC, E1_INS); end
  endtask
  task automatic test_reset_mid();
    begin_frame();
    send_bits(F3, 0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({cfunc, cins} !== 30'd0) begin bad++; $display("FAIL midrst_conf got=%h/%h want=0/0", cfunc, cins); end
    total++; if ({ready, busy, done, err} !== 4'b0) begin bad++; $display("FAIL midrst_flags got=%b want=0000", {ready, busy, done, err}); end
    begin_frame();
    total++; if ({ready, busy} !== 2'b11) begin bad++; $display("FAIL midrst_start got=%b want=11", {ready, busy}); end
    send_bits(F3, 0, 30);
    tick();
    total++; if ({done, cfunc, cins} !== {1'b1, E3_FUNC, E3_INS}) begin bad++; $display("FAIL midrst_load got=%b/%h/%h want=1/%h/%h", done, cfunc, cins, E3_FUNC, E3_INS); end
  endtask
  task automatic test_start_ignored();
    begin_frame();
    send_bits(F1, 0, 10);
    start = 1'b1;
    send_bits(F1, 10, 5);
    start = 1'b0;
    total++; if ({dut.gene_cnt_q, dut.bit_cnt_q, busy} !== {2'd1, 4'd0, 1'b1}) begin bad++; $display("FAIL start_in_load got=%0d/%0d/%b want=1/0/1", dut.gene_cnt_q, dut.bit_cnt_q, busy); end
    send_bits(F1, 15, 15);
    tick();
    total++; if ({done, cfunc, cins} !== {1'b1, E1_FUNC, E1_INS}) begin bad++; $display("FAIL start_in_load_conf got=%b/%h/%h want=1/%h/%h", done, cfunc, cins, E1_FUNC, E1_INS); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    tick();
    total++; if ({ready, busy} !== 2'b00) begin bad++; $display("FAIL start_abort got=%b want=00", {ready, busy}); end
    start = 1'b0;
    abort = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_after got=%b want=0", busy); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_select();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
